// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data cache: geometry, address fields
// and the controller state encoding.
package dcache_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int INDEX_W   = 4;
    localparam int OFFSET_W  = 2;
    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES     = 1 << INDEX_W;
    localparam int WORDS     = 1 << OFFSET_W;
    localparam int TAG_LSB   = INDEX_W + OFFSET_W;
    localparam int INDEX_LSB = OFFSET_W;

    // Offset of the last word of a block; the refill ends after this word
    localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:TAG_LSB];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[TAG_LSB-1:INDEX_LSB];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache. Reads are
// combinational; all writes happen on the rising clock edge. Only the valid
// bits are reset, tags and data come up undefined.
module dcache_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic                fill_we,
    input  logic [OFFSET_W-1:0] fill_offset,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                store_we,
    input  logic [OFFSET_W-1:0] store_offset,
    input  logic [DATA_W-1:0]   store_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    tag_data,
    input  logic                inval_we
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES][WORDS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_offset];

    // Valid bits: cleared when a refill starts, set when the tag is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (inval_we) valid[wr_index] <= 1'b0;
            if (tag_we)   valid[wr_index] <= 1'b1;
        end
    end

    // Tag write at the end of a refill
    always_ff @(posedge clk) begin
        if (tag_we) tags[wr_index] <= tag_data;
    end

    // Data write: refill word or write-through store word
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data[wr_index][fill_offset] <= fill_data;
        end else if (store_we) begin
            data[wr_index][store_offset] <= store_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for
// the MEM stage. Read misses refill a whole block word by word; stores always
// go to memory and update the cached word only when the line is present.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    state_t              state;
    state_t              next_state;
    logic [OFFSET_W-1:0] cnt;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;

    logic [ADDR_W-1:0]   look_addr;
    logic                look_valid;
    logic [TAG_W-1:0]    look_tag;
    logic [DATA_W-1:0]   look_data;
    logic                look_hit;

    logic                start_req;
    logic                cnt_inc;
    logic                fill_we;
    logic                store_we;
    logic                tag_we;
    logic                inval_we;

    // In IDLE the live pipeline address is looked up; once a transaction is
    // running, the latched request address drives the lookup and all writes.
    assign look_addr = (state == IDLE) ? addr : req_addr;
    assign look_hit  = look_valid && (look_tag == addr_tag(look_addr));

    dcache_array u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_index     (addr_index(look_addr)),
        .rd_offset    (addr_offset(look_addr)),
        .rd_valid     (look_valid),
        .rd_tag       (look_tag),
        .rd_data      (look_data),
        .wr_index     (addr_index(look_addr)),
        .fill_we      (fill_we),
        .fill_offset  (cnt),
        .fill_data    (mem_rdata),
        .store_we     (store_we),
        .store_offset (addr_offset(req_addr)),
        .store_data   (req_wdata),
        .tag_we       (tag_we),
        .tag_data     (addr_tag(req_addr)),
        .inval_we     (inval_we)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latch and refill word counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else if (start_req) begin
            cnt       <= '0;
            req_addr  <= addr;
            req_wdata <= wdata;
        end else if (cnt_inc) begin
            cnt <= cnt + OFFSET_W'(1);
        end
    end

    // Next state, pipeline handshake, memory handshake and array write enables;
    // nothing here depends combinationally on mem_ack except array/state updates
    always_comb begin
        next_state = state;
        hit        = 1'b0;
        rdata      = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        start_req  = 1'b0;
        cnt_inc    = 1'b0;
        fill_we    = 1'b0;
        store_we   = 1'b0;
        tag_we     = 1'b0;
        inval_we   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    start_req  = 1'b1;
                    next_state = WRITE;
                end else if (mem_read) begin
                    if (look_hit) begin
                        hit   = 1'b1;
                        rdata = look_data;
                    end else begin
                        start_req  = 1'b1;
                        inval_we   = 1'b1;
                        next_state = FILL;
                    end
                end else begin
                    hit = 1'b1;
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_addr[ADDR_W-1:OFFSET_W], cnt};
                if (mem_ack) begin
                    fill_we = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == LAST_WORD) begin
                        tag_we     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = req_addr;
                mem_wdata = req_wdata;
                if (mem_ack) begin
                    store_we   = look_hit;
                    next_state = WDONE;
                end
            end
            WDONE: begin
                hit        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule
